// File: rtl/cam_search_initiator.sv
// cam_search_initiator: requester-side search engine for one read port of the
// partitioned CAM. Accepts a tag, performs a one-cycle CAM lookup, masks out
// power-gated partitions and returns every matching index lowest-first.
// Optional macro CAM_SEARCH_COUNT_EN adds rsp_count_o, the number of hits of
// the current search.
module cam_search_initiator #(
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int WIDTH         = 8,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  input  logic [WIDTH-1:0]     req_tag_i,
  output logic                 req_ready_o,
  input  logic [NUM_PARTS-1:0] partitionGated_i,
  input  logic                 ramReady_i,
  output logic [WIDTH-1:0]     camTag_o,
  output logic                 readPortGated_o,
  input  logic [DEPTH-1:0]     camVect_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [INDEX-1:0]     rsp_index_o,
  output logic                 rsp_last_o
`ifdef CAM_SEARCH_COUNT_EN
  ,
  output logic [INDEX:0]       rsp_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, EMIT} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tag_q, tag_d;
  logic [DEPTH-1:0]   mask_q, mask_d;
  logic               init_q;
  logic [DEPTH-1:0]   gate_vec;
  logic [DEPTH-1:0]   new_mask;
  logic [DEPTH-1:0]   mask_rest;
  logic [INDEX-1:0]   first_idx;
  logic [INDEX-1:0]   ent;
  logic               accept;
  logic               rsp_fire;

  // Per-entry gate: the top NUM_PARTS_LOG bits of an entry index name its partition
  always_comb begin
    gate_vec = '0;
    ent      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent         = INDEX'(i);
      gate_vec[i] = partitionGated_i[ent[INDEX-1 -: NUM_PARTS_LOG]];
    end
  end

  assign new_mask  = camVect_i & ~gate_vec;
  // Clearing the lowest set bit; an all-zero remainder means the current response is the last
  assign mask_rest = mask_q & (mask_q - DEPTH'(1));

  // Priority encoder: lowest set bit of the captured mask wins
  always_comb begin
    first_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (mask_q[i-1]) first_idx = INDEX'(i - 1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: tag, match snapshot and post-reset ready qualifier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= '0;
      mask_q <= '0;
      init_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      mask_q <= mask_d;
      init_q <= 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tag_d   = req_tag_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (ramReady_i) begin
          mask_d  = new_mask;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rsp_fire) begin
          mask_d = mask_rest;
          if (rsp_last_o) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and the captured mask
  always_comb begin
    req_ready_o     = (state_q == IDLE) && ramReady_i && init_q;
    readPortGated_o = (state_q != LOOKUP);
    camTag_o        = tag_q;
    rsp_valid_o     = (state_q == EMIT);
    rsp_hit_o       = (state_q == EMIT) && (|mask_q);
    rsp_index_o     = (state_q == EMIT) ? first_idx : '0;
    rsp_last_o      = (state_q == EMIT) && !(|mask_rest);
  end

  assign accept   = req_valid_i && req_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;

`ifdef CAM_SEARCH_COUNT_EN
  logic [INDEX:0] count_q, count_d;
  logic [INDEX:0] new_count;

  // Popcount of the mask about to be captured
  always_comb begin
    new_count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      new_count = new_count + (INDEX+1)'(new_mask[i]);
    end
  end

  // Hit count is captured with the mask and held for the whole request
  always_comb begin
    count_d = count_q;
    if (state_q == LOOKUP && ramReady_i) count_d = new_count;
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign rsp_count_o = count_q;
`endif

endmodule

// File: tb/tb_cam_search_initiator.sv
// tb_cam_search_initiator: directed and random searches against a queue-based
// reference of expected hit indices.
module tb_cam_search_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_tag = '0;
  logic        req_ready_o;
  logic [3:0]  pgated = '0;
  logic        ram_ready = 1'b0;
  logic [7:0]  camTag_o;
  logic        readPortGated_o;
  logic [31:0] cam_vect = '0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit_o;
  logic [4:0]  rsp_index_o;
  logic        rsp_last_o;
`ifdef CAM_SEARCH_COUNT_EN
  logic [5:0]  rsp_count_o;
`endif

  int checks = 0;
  int failures = 0;

  cam_search_initiator #(
    .DEPTH(32), .INDEX(5), .WIDTH(8), .NUM_PARTS(4), .NUM_PARTS_LOG(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_tag_i        (req_tag),
    .req_ready_o      (req_ready_o),
    .partitionGated_i (pgated),
    .ramReady_i       (ram_ready),
    .camTag_o         (camTag_o),
    .readPortGated_o  (readPortGated_o),
    .camVect_i        (cam_vect),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_hit_o        (rsp_hit_o),
    .rsp_index_o      (rsp_index_o),
    .rsp_last_o       (rsp_last_o)
`ifdef CAM_SEARCH_COUNT_EN
    ,
    .rsp_count_o      (rsp_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string where);
    chk({where, "_req_ready"}, req_ready_o, 0);
    chk({where, "_port_gated"}, readPortGated_o, 1);
    chk({where, "_cam_tag"}, camTag_o, 0);
    chk({where, "_rsp_valid"}, rsp_valid_o, 0);
    chk({where, "_rsp_hit"}, rsp_hit_o, 0);
    chk({where, "_rsp_index"}, rsp_index_o, 0);
    chk({where, "_rsp_last"}, rsp_last_o, 0);
`ifdef CAM_SEARCH_COUNT_EN
    chk({where, "_count"}, rsp_count_o, 0);
`endif
  endtask

  // One full search: request, LOOKUP (with ram_low stalled cycles), all responses.
  // Expected responses are the ascending list of set, ungated entry indices.
  task automatic search(input logic [7:0] tag, input logic [31:0] vec, input logic [3:0] gate,
                        input int ram_low, input int stall_first, input bit rnd_ready);
    int q[$];
    int n;
    int nrsp;
    int stalls;
    bit rdy;
    for (int i = 0; i < 32; i++)
      if (vec[i] && !gate[i / 8]) q.push_back(i);
    n = q.size();
    nrsp = (n == 0) ? 1 : n;

    @(negedge clk);
    req_valid = 1'b1; req_tag = tag; ram_ready = 1'b1; rsp_ready = 1'b0;
    #1 chk("accept_ready", req_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_tag = 8'($urandom); cam_vect = vec; pgated = gate;
    for (int k = 0; k <= ram_low; k++) begin
      if (k > 0) @(negedge clk);
      ram_ready = (k < ram_low) ? 1'b0 : 1'b1;
      #1;
      chk("lookup_port_gated", readPortGated_o, 0);
      chk("lookup_cam_tag", camTag_o, tag);
      chk("lookup_req_ready", req_ready_o, 0);
      chk("lookup_rsp_valid", rsp_valid_o, 0);
      @(posedge clk);
    end

    for (int r = 0; r < nrsp; r++) begin
      stalls = 0;
      do begin
        @(negedge clk);
        // Inputs change freely during EMIT; the captured snapshot must not move
        cam_vect = $urandom; pgated = 4'($urandom); ram_ready = 1'($urandom);
        if (r == 0 && stalls < stall_first) rdy = 1'b0;
        else if (rnd_ready && stalls < 3)   rdy = 1'($urandom);
        else                                rdy = 1'b1;
        rsp_ready = rdy;
        #1;
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_hit", rsp_hit_o, (n > 0) ? 1 : 0);
        chk("rsp_index", rsp_index_o, (n > 0) ? q[r] : 0);
        chk("rsp_last", rsp_last_o, (r == nrsp - 1) ? 1 : 0);
        chk("emit_port_gated", readPortGated_o, 1);
        chk("emit_cam_tag", camTag_o, tag);
        chk("emit_req_ready", req_ready_o, 0);
`ifdef CAM_SEARCH_COUNT_EN
        chk("rsp_count", rsp_count_o, n);
`endif
        @(posedge clk);
        stalls++;
      end while (!rdy);
    end

    @(negedge clk);
    rsp_ready = 1'b0; ram_ready = 1'b1;
    #1;
    chk("idle_rsp_valid", rsp_valid_o, 0);
    chk("idle_req_ready", req_ready_o, 1);
    chk("idle_port_gated", readPortGated_o, 1);
  endtask

  initial begin
    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1; ram_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", req_ready_o, 1);

    // IDLE with the CAM still initialising must not accept
    @(negedge clk); ram_ready = 1'b0;
    #1 chk("ram_not_ready", req_ready_o, 0);

    search(8'h3A, 32'h0000_8012, 4'b0000, 0, 0, 1'b0);
    search(8'h3A, 32'h0000_8012, 4'b0001, 0, 0, 1'b0);
    search(8'h55, 32'h0000_0000, 4'b0000, 0, 0, 1'b0);
    search(8'h21, 32'h0000_0006, 4'b0000, 0, 3, 1'b0);
    search(8'hC3, 32'h8000_0001, 4'b0000, 2, 0, 1'b0);
    search(8'hFF, 32'hFFFF_FFFF, 4'b1111, 0, 0, 1'b0);
    search(8'h01, 32'hFFFF_FFFF, 4'b0110, 0, 0, 1'b1);

    // Asynchronous reset in the middle of EMIT
    @(negedge clk);
    req_valid = 1'b1; req_tag = 8'h77; ram_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0; cam_vect = 32'h0000_00F0; pgated = '0;
    @(posedge clk);
    @(negedge clk); rsp_ready = 1'b0;
    #1 chk("pre_reset_rsp_valid", rsp_valid_o, 1);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_release_ready", req_ready_o, 1);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = $urandom & $urandom & $urandom;
        2: v = $urandom;
        default: v = 32'h1 << $urandom_range(0, 31);
      endcase
      search(8'($urandom), v, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
             $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
